cpu_rf_banked: RTL and testbench

- Register file directly downstream of the writeback mux; consumes its 16-bit rf_wd output as the write-data input.
- Holds two banks of general registers: NORMAL (bank 0) and INTERRUPT (bank 1).
- The FSM switches banks on interrupt entry and return, so handlers never clobber user registers.
- Two combinational read ports feed the decode/ALU stage.

---
 rtl/cpu_rf_pkg.sv | 15 +
 rtl/cpu_rf_bank.sv | 43 ++++
 rtl/cpu_rf_banked.sv | 102 ++++++++++
 tb/tb_cpu_rf_banked.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_rf_pkg.sv
// Shared constants and state type for the banked register file.
package cpu_rf_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 3;

    localparam logic BANK_NORMAL = 1'b0;
    localparam logic BANK_INT    = 1'b1;

    typedef enum logic {
        NORMAL    = BANK_NORMAL,
        INTERRUPT = BANK_INT
    } state_t;

endpackage

// File: rtl/cpu_rf_bank.sv
// One register bank: 2**AW x DW storage, one write port, two async read ports.
// Register 0 is hardwired to zero.
module cpu_rf_bank
    import cpu_rf_pkg::*;
#(
    parameter int   DW       = DW_DEF,
    parameter int   AW       = AW_DEF,
    parameter logic BANK_IDX = BANK_NORMAL
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          rf_we,
    input  logic          bank_sel,
    input  logic [AW-1:0] rf_wa,
    input  logic [DW-1:0] rf_wd,
    input  logic [AW-1:0] rf_ra1,
    input  logic [AW-1:0] rf_ra2,
    output logic [DW-1:0] rf_rd1,
    output logic [DW-1:0] rf_rd2
);

    localparam int NREG = 2**AW;

    logic [DW-1:0] mem [NREG];
    logic          we_own;

    // bank_sel is the pre-edge state, so a write coinciding with a switch lands here
    assign we_own = rf_we && (bank_sel == BANK_IDX) && (rf_wa != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we_own) begin
            mem[rf_wa] <= rf_wd;
        end
    end

    assign rf_rd1 = (rf_ra1 == '0) ? '0 : mem[rf_ra1];
    assign rf_rd2 = (rf_ra2 == '0) ? '0 : mem[rf_ra2];

endmodule

// File: rtl/cpu_rf_banked.sv
// Two-bank register file with interrupt-context bank switching FSM.
// Optional write-through forwarding enabled by defining CPU_RF_BYPASS_EN.
//
// state     | meaning
// NORMAL    | user context, bank 0 active
// INTERRUPT | handler context, bank 1 active
module cpu_rf_banked
    import cpu_rf_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          rf_we,
    input  logic [AW-1:0] rf_wa,
    input  logic [DW-1:0] rf_wd,
    input  logic [AW-1:0] rf_ra1,
    input  logic [AW-1:0] rf_ra2,
    output logic [DW-1:0] rf_rd1,
    output logic [DW-1:0] rf_rd2,
    input  logic          int_enter,
    input  logic          int_return,
    output logic          bank_sel,
    output logic          seq_err
);

    state_t        state, state_nxt;
    logic          err_set;
    logic [DW-1:0] b0_rd1, b0_rd2, b1_rd1, b1_rd2;
    logic [DW-1:0] mem_rd1, mem_rd2;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= NORMAL;
            seq_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (err_set) begin
                seq_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        case ({int_enter, int_return})
            2'b10: begin
                if (state == NORMAL) state_nxt = INTERRUPT;
                else                 err_set   = 1'b1;
            end
            2'b01: begin
                if (state == INTERRUPT) state_nxt = NORMAL;
                else                    err_set   = 1'b1;
            end
            2'b11:   err_set = 1'b1;
            default: ;
        endcase
    end

    assign bank_sel = state;

    cpu_rf_bank #(.DW(DW), .AW(AW), .BANK_IDX(BANK_NORMAL)) u_bank0 (
        .clock    (clock),
        .reset    (reset),
        .rf_we    (rf_we),
        .bank_sel (bank_sel),
        .rf_wa    (rf_wa),
        .rf_wd    (rf_wd),
        .rf_ra1   (rf_ra1),
        .rf_ra2   (rf_ra2),
        .rf_rd1   (b0_rd1),
        .rf_rd2   (b0_rd2)
    );

    cpu_rf_bank #(.DW(DW), .AW(AW), .BANK_IDX(BANK_INT)) u_bank1 (
        .clock    (clock),
        .reset    (reset),
        .rf_we    (rf_we),
        .bank_sel (bank_sel),
        .rf_wa    (rf_wa),
        .rf_wd    (rf_wd),
        .rf_ra1   (rf_ra1),
        .rf_ra2   (rf_ra2),
        .rf_rd1   (b1_rd1),
        .rf_rd2   (b1_rd2)
    );

    assign mem_rd1 = (bank_sel == BANK_INT) ? b1_rd1 : b0_rd1;
    assign mem_rd2 = (bank_sel == BANK_INT) ? b1_rd2 : b0_rd2;

`ifdef CPU_RF_BYPASS_EN
    // Writes only ever hit the active bank, so the address match alone decides forwarding
    assign rf_rd1 = (rf_we && (rf_wa != '0) && (rf_ra1 == rf_wa)) ? rf_wd : mem_rd1;
    assign rf_rd2 = (rf_we && (rf_wa != '0) && (rf_ra2 == rf_wa)) ? rf_wd : mem_rd2;
`else
    assign rf_rd1 = mem_rd1;
    assign rf_rd2 = mem_rd2;
`endif

endmodule

// File: tb/tb_cpu_rf_banked.sv
// Directed self-checking bench for cpu_rf_banked (bank switching, seq_err, r0, reset, bypass).
module tb_cpu_rf_banked;

    logic        clock = 1'b0;
    logic        reset;
    logic        rf_we;
    logic [2:0]  rf_wa;
    logic [15:0] rf_wd;
    logic [2:0]  rf_ra1;
    logic [2:0]  rf_ra2;
    logic [15:0] rf_rd1;
    logic [15:0] rf_rd2;
    logic        int_enter;
    logic        int_return;
    logic        bank_sel;
    logic        seq_err;

    int checks = 0;
    int errors = 0;

    cpu_rf_banked #(.DW(16), .AW(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .rf_we      (rf_we),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
        .rf_ra1     (rf_ra1),
        .rf_ra2     (rf_ra2),
        .rf_rd1     (rf_rd1),
        .rf_rd2     (rf_rd2),
        .int_enter  (int_enter),
        .int_return (int_return),
        .bank_sel   (bank_sel),
        .seq_err    (seq_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one rising edge, leave inputs to change 1ns after it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        rf_we = 1'b1; rf_wa = a; rf_wd = d;
        tick();
        rf_we = 1'b0;
    endtask

    task automatic pulse_enter();
        int_enter = 1'b1;
        tick();
        int_enter = 1'b0;
    endtask

    task automatic pulse_return();
        int_return = 1'b1;
        tick();
        int_return = 1'b0;
    endtask

    task automatic rd1(input logic [2:0] a, input string tag, input logic [15:0] exp);
        rf_ra1 = a;
        #1;
        chk(tag, rf_rd1, exp);
    endtask

    task automatic rd2(input logic [2:0] a, input string tag, input logic [15:0] exp);
        rf_ra2 = a;
        #1;
        chk(tag, rf_rd2, exp);
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 8; i++) begin
            rf_ra1 = 3'(i);
            rf_ra2 = 3'(7 - i);
            #1;
            chk({tag, "_rd1"}, rf_rd1, 16'h0000);
            chk({tag, "_rd2"}, rf_rd2, 16'h0000);
        end
    endtask

    initial begin
        reset = 1'b1; rf_we = 1'b0; rf_wa = '0; rf_wd = '0;
        rf_ra1 = '0; rf_ra2 = '0; int_enter = 1'b0; int_return = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check_all_zero("reset_bank0");
        chk("reset_bank_sel", 16'(bank_sel), 16'd0);
        chk("reset_seq_err", 16'(seq_err), 16'd0);

        // bank isolation and preservation
        wr(3'd3, 16'h1234);
        rd1(3'd3, "n_r3_write", 16'h1234);
        pulse_enter();
        chk("enter_bank_sel", 16'(bank_sel), 16'd1);
        rd1(3'd3, "i_r3_fresh", 16'h0000);
        wr(3'd3, 16'hBEEF);
        rd2(3'd3, "i_r3_write", 16'hBEEF);
        pulse_return();
        chk("return_bank_sel", 16'(bank_sel), 16'd0);
        rd1(3'd3, "n_r3_kept", 16'h1234);
        pulse_enter();
        rd1(3'd3, "i_r3_kept", 16'hBEEF);
        pulse_return();

        // write coincides with bank switch: lands in the old bank
        rf_we = 1'b1; rf_wa = 3'd5; rf_wd = 16'hAAAA; int_enter = 1'b1;
        tick();
        rf_we = 1'b0; int_enter = 1'b0;
        chk("sw_bank_sel", 16'(bank_sel), 16'd1);
        rd1(3'd5, "sw_i_r5", 16'h0000);
        pulse_return();
        rd2(3'd5, "sw_n_r5", 16'hAAAA);
        chk("legal_seq_err", 16'(seq_err), 16'd0);

        // illegal: return in NORMAL
        pulse_return();
        chk("ret_in_n_bank", 16'(bank_sel), 16'd0);
        chk("ret_in_n_err", 16'(seq_err), 16'd1);
        pulse_enter();
        chk("err_sticky_bank", 16'(bank_sel), 16'd1);
        chk("err_sticky_err", 16'(seq_err), 16'd1);
        pulse_return();
        chk("err_sticky2_err", 16'(seq_err), 16'd1);

        // illegal: enter in INTERRUPT
        do_reset();
        chk("rst_clears_err", 16'(seq_err), 16'd0);
        pulse_enter();
        chk("nest_pre_err", 16'(seq_err), 16'd0);
        pulse_enter();
        chk("nest_bank", 16'(bank_sel), 16'd1);
        chk("nest_err", 16'(seq_err), 16'd1);

        // illegal: both together, in each state
        do_reset();
        int_enter = 1'b1; int_return = 1'b1;
        tick();
        int_enter = 1'b0; int_return = 1'b0;
        chk("both_n_bank", 16'(bank_sel), 16'd0);
        chk("both_n_err", 16'(seq_err), 16'd1);
        do_reset();
        pulse_enter();
        int_enter = 1'b1; int_return = 1'b1;
        tick();
        int_enter = 1'b0; int_return = 1'b0;
        chk("both_i_bank", 16'(bank_sel), 16'd1);
        chk("both_i_err", 16'(seq_err), 16'd1);
        do_reset();

        // register 0 hardwired
        wr(3'd0, 16'hFFFF);
        rd1(3'd0, "r0_write", 16'h0000);
        rd2(3'd0, "r0_write_p2", 16'h0000);

        // same-cycle read/write
        wr(3'd2, 16'h1111);
        rf_we = 1'b1; rf_wa = 3'd2; rf_wd = 16'h5A5A; rf_ra1 = 3'd2; rf_ra2 = 3'd3;
        #1;
`ifdef CPU_RF_BYPASS_EN
        chk("bypass_rd1", rf_rd1, 16'h5A5A);
`else
        chk("nobypass_rd1", rf_rd1, 16'h1111);
`endif
        chk("bypass_other_port", rf_rd2, 16'h0000);
        tick();
        rf_we = 1'b0;
        rd1(3'd2, "after_write_rd1", 16'h5A5A);
        rf_we = 1'b1; rf_wa = 3'd0; rf_wd = 16'h7777; rf_ra1 = 3'd0;
        #1;
        chk("bypass_r0", rf_rd1, 16'h0000);
        tick();
        rf_we = 1'b0;

        // reset mid-stream overrides write and enter
        wr(3'd4, 16'h4444);
        pulse_enter();
        wr(3'd6, 16'h6666);
        rd1(3'd6, "pre_rst_i_r6", 16'h6666);
        reset = 1'b1; rf_we = 1'b1; rf_wa = 3'd7; rf_wd = 16'h9999; int_enter = 1'b1;
        tick();
        reset = 1'b0; rf_we = 1'b0; int_enter = 1'b0;
        chk("mid_rst_bank", 16'(bank_sel), 16'd0);
        chk("mid_rst_err", 16'(seq_err), 16'd0);
        check_all_zero("mid_rst_bank0");
        pulse_enter();
        check_all_zero("mid_rst_bank1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
